// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared uart constants for the receive FIFO slice
package uart_rx_fifo_pkg;

    // Width of one received UART character.
    localparam int BYTE_W = 8;

    // Default number of FIFO entries behind the receiver.
    localparam int FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - DEPTH x BYTE_W register array, one write port, async read port
module uart_rx_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Storage is not reset; validity of each entry is tracked by the pointers in the parent.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head entry is visible combinationally so the consumer sees it without a read cycle.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO capturing Uart8 frames on the rxDone rising edge
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH_DEFAULT,
    parameter int DROP_ERR = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rxDone,
    input  logic                    rxErr,
    input  logic [BYTE_W-1:0]       rxByte,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [BYTE_W-1:0]       outByte,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    overflow,
    output logic                    errSeen,
    input  logic                    clrFlags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rx_done_prev_q;
    logic          rx_armed_q, rx_armed_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          err_seen_q, err_seen_d;

    logic              strobe;
    logic              not_empty;
    logic              full_w;
    logic              rd_en;
    logic              drop_err_byte;
    logic              wr_en;
    logic              ovf_set;
    logic              err_set;
    logic [BYTE_W-1:0] head_byte;

    // Capture, read and flag-update decisions plus next-state for pointers and count.
    always_comb begin
        // rx_armed_q blocks a capture until rxDone has been seen low after reset,
        // so a frame already in progress at reset release is never taken.
        rx_armed_d    = rx_armed_q | ~rxDone;
        strobe        = rxDone & ~rx_done_prev_q & rx_armed_q;
        not_empty     = (count_q != '0);
        full_w        = (count_q == CW'(DEPTH));
        rd_en         = not_empty & outReady;
        drop_err_byte = (DROP_ERR != 0) & rxErr;
        // A read in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en         = strobe & ~drop_err_byte & (~full_w | rd_en);
        ovf_set       = strobe & ~drop_err_byte & full_w & ~rd_en;
        err_set       = strobe & rxErr;

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Setting has priority over a same-cycle clear so no event is lost.
        overflow_d = (overflow_q & ~clrFlags) | ovf_set;
        err_seen_d = (err_seen_q & ~clrFlags) | err_set;
    end

    // Control state register; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_done_prev_q <= 1'b0;
            rx_armed_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            err_seen_q     <= 1'b0;
        end else begin
            rx_done_prev_q <= rxDone;
            rx_armed_q     <= rx_armed_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            err_seen_q     <= err_seen_d;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (rxByte),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_byte)
    );

    // Head byte is forced to zero when empty so stale storage never leaks out.
    assign outValid = not_empty;
    assign outByte  = not_empty ? head_byte : '0;
    assign count    = count_q;
    assign full     = full_w;
    assign overflow = overflow_q;
    assign errSeen  = err_seen_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxByte;
    logic       outReady;
    logic       clrFlags;

    logic       outValid, full, overflow, errSeen;
    logic [7:0] outByte;
    logic [4:0] count;

    logic       k_outValid, k_full, k_overflow, k_errSeen;
    logic [7:0] k_outByte;
    logic [4:0] k_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    uart_rx_fifo #(.DEPTH(16), .DROP_ERR(1)) dut (
        .clk(clk), .rst(rst), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
        .outValid(outValid), .outReady(outReady), .outByte(outByte), .count(count),
        .full(full), .overflow(overflow), .errSeen(errSeen), .clrFlags(clrFlags)
    );

    uart_rx_fifo #(.DEPTH(16), .DROP_ERR(0)) dut_keep (
        .clk(clk), .rst(rst), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
        .outValid(k_outValid), .outReady(outReady), .outByte(k_outByte), .count(k_count),
        .full(k_full), .overflow(k_overflow), .errSeen(k_errSeen), .clrFlags(clrFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] b, input logic err, input int hold);
        rxByte = b;
        rxErr  = err;
        rxDone = 1'b1;
        repeat (hold) step();
        rxDone = 1'b0;
        rxErr  = 1'b0;
        repeat (2) step();
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every byte the consumer takes is compared against the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read", {24'h0, outByte}, 32'hFFFF_FFFF);
            end else begin
                exp_b = exp_q.pop_front();
                chk("read_byte", {24'h0, outByte}, {24'h0, exp_b});
            end
        end
    end

    initial begin : stim
        logic [7:0] lb [20];
        lb = '{8'd30, 8'd24, 8'd19, 8'd25, 8'd91, 8'd77, 8'd1, 8'd0, 8'd99, 8'd15,
               8'd100, 8'd128, 8'd255, 8'd254, 8'd0, 8'd10, 8'd43, 8'd149, 8'd7, 8'd2};

        rst = 1'b1; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
        outReady = 1'b0; clrFlags = 1'b0;
        repeat (3) step();
        chk("rst_count", count, 0);
        chk("rst_outValid", outValid, 0);
        chk("rst_full", full, 0);
        chk("rst_outByte", outByte, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_errSeen", errSeen, 0);
        rst = 1'b0;
        repeat (2) step();

        // Loopback stream consumed as it arrives.
        outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(lb[i]);
            frame(lb[i], 1'b0, 3);
        end
        wait_drain("loop_drain");
        chk("loop_count", count, 0);
        chk("loop_overflow", overflow, 0);
        chk("loop_errSeen", errSeen, 0);

        // Long rxDone level gives one capture only.
        outReady = 1'b0;
        rxByte = 8'hA5; rxErr = 1'b0; rxDone = 1'b1;
        step();
        chk("held_count_1st", count, 1);
        chk("held_outByte", outByte, 8'hA5);
        chk("held_outValid", outValid, 1);
        repeat (6) step();
        chk("held_count_end", count, 1);
        rxDone = 1'b0;
        step();
        exp_q.push_back(8'hA5);
        outReady = 1'b1;
        wait_drain("held_drain");
        chk("held_empty", count, 0);

        // Seventeen frames into a sixteen-entry FIFO with no reads.
        outReady = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            frame(8'(i), 1'b0, 2);
        end
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", outByte, 8'h00);
        clrFlags = 1'b1;
        step();
        clrFlags = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Capture while full coincides with a read: byte accepted, no overflow.
        rxByte = 8'h3C; rxDone = 1'b1; outReady = 1'b1;
        exp_q.push_back(8'h3C);
        step();
        outReady = 1'b0;
        chk("bnd_count", count, 16);
        chk("bnd_full", full, 1);
        chk("bnd_overflow", overflow, 0);
        rxDone = 1'b0;
        step();
        outReady = 1'b1;
        wait_drain("bnd_drain");
        chk("bnd_empty", count, 0);
        outReady = 1'b0;

        // Errored frame: dropped by the default instance, kept by the DROP_ERR=0 instance.
        frame(8'h55, 1'b1, 3);
        chk("err_drop_count", count, 0);
        chk("err_drop_seen", errSeen, 1);
        chk("err_keep_count", k_count, 1);
        chk("err_keep_byte", k_outByte, 8'h55);
        chk("err_keep_seen", k_errSeen, 1);
        clrFlags = 1'b1;
        step();
        clrFlags = 1'b0;
        chk("err_cleared", errSeen, 0);
        rxByte = 8'h66; rxErr = 1'b1; rxDone = 1'b1; clrFlags = 1'b1;
        step();
        clrFlags = 1'b0; rxDone = 1'b0; rxErr = 1'b0;
        chk("err_set_wins", errSeen, 1);
        step();

        // Reset with five stored bytes and a frame in progress.
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 5; i++) frame(8'h80 + 8'(i), 1'b0, 2);
        chk("rst5_count", count, 5);
        rxByte = 8'h77; rxDone = 1'b1; rst = 1'b1;
        #1;
        chk("rst5_count_now", count, 0);
        chk("rst5_valid_now", outValid, 0);
        chk("rst5_byte_now", outByte, 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
        chk("rst5_no_capture", count, 0);
        rxDone = 1'b0;
        step();
        exp_q.push_back(8'h42);
        frame(8'h42, 1'b0, 2);
        chk("rst5_new_capture", count, 1);
        outReady = 1'b1;
        wait_drain("rst5_drain");
        chk("rst5_empty", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
